// File: rtl/rho_pi_inv_serial.sv
// Lane-serial inverse of the Keccak rho+pi step: buffers 25 post-rho-pi lanes,
// then streams the pre-rho-pi state back out in lane index order.
module rho_pi_inv_serial #(
    parameter bit BYPASS_RHO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        m_last,
    output logic        busy
);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]  state;
    logic [4:0]  wr_cnt;
    logic [4:0]  rd_cnt;
    logic [63:0] lanes [25];
    logic        in_hs;
    logic        out_hs;
    logic [4:0]  rd_src;
    logic [5:0]  rd_rot;

    // Buffer index holding the source of output lane m (inverse pi).
    function automatic logic [4:0] src_lane(input logic [4:0] m);
        logic [4:0] s;
        case (m)
            5'd0:  s = 5'd0;   5'd1:  s = 5'd10;  5'd2:  s = 5'd20;  5'd3:  s = 5'd5;
            5'd4:  s = 5'd15;  5'd5:  s = 5'd16;  5'd6:  s = 5'd1;   5'd7:  s = 5'd11;
            5'd8:  s = 5'd21;  5'd9:  s = 5'd6;   5'd10: s = 5'd7;   5'd11: s = 5'd17;
            5'd12: s = 5'd2;   5'd13: s = 5'd12;  5'd14: s = 5'd22;  5'd15: s = 5'd23;
            5'd16: s = 5'd8;   5'd17: s = 5'd18;  5'd18: s = 5'd3;   5'd19: s = 5'd13;
            5'd20: s = 5'd14;  5'd21: s = 5'd24;  5'd22: s = 5'd9;   5'd23: s = 5'd19;
            5'd24: s = 5'd4;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    // Right-rotation that undoes the rho offset of output lane m.
    function automatic logic [5:0] rot_amt(input logic [4:0] m);
        logic [5:0] k;
        case (m)
            5'd0:  k = 6'd0;   5'd1:  k = 6'd1;   5'd2:  k = 6'd62;  5'd3:  k = 6'd28;
            5'd4:  k = 6'd27;  5'd5:  k = 6'd36;  5'd6:  k = 6'd44;  5'd7:  k = 6'd6;
            5'd8:  k = 6'd55;  5'd9:  k = 6'd20;  5'd10: k = 6'd3;   5'd11: k = 6'd10;
            5'd12: k = 6'd43;  5'd13: k = 6'd25;  5'd14: k = 6'd39;  5'd15: k = 6'd41;
            5'd16: k = 6'd45;  5'd17: k = 6'd15;  5'd18: k = 6'd21;  5'd19: k = 6'd8;
            5'd20: k = 6'd18;  5'd21: k = 6'd2;   5'd22: k = 6'd61;  5'd23: k = 6'd56;
            5'd24: k = 6'd14;
            default: k = 6'd0;
        endcase
        return k;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] k);
        logic [127:0] d;
        d = {x, x} >> k;
        return d[63:0];
    endfunction

    // Outputs are gated by rst_n so they read idle for the whole reset cycle.
    assign s_ready = rst_n && (state == FILL);
    assign m_valid = rst_n && (state == DRAIN);
    assign m_last  = m_valid && (rd_cnt == 5'd24);
    assign busy    = rst_n && ((state == DRAIN) || (wr_cnt != 5'd0));
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;

    always_comb begin
        rd_src = src_lane(rd_cnt);
        rd_rot = BYPASS_RHO ? 6'd0 : rot_amt(rd_cnt);
        m_data = '0;
        if (m_valid) begin
            m_data = rotr(lanes[rd_src], rd_rot);
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            lanes[wr_cnt] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (state == FILL) begin
            if (in_hs) begin
                if (wr_cnt == 5'd24) begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    state  <= DRAIN;
                end else begin
                    wr_cnt <= wr_cnt + 5'd1;
                end
            end
        end else begin
            if (out_hs) begin
                if (rd_cnt == 5'd24) begin
                    rd_cnt <= '0;
                    state  <= FILL;
                end else begin
                    rd_cnt <= rd_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rho_pi_inv_serial.sv
// Directed bench for rho_pi_inv_serial: normal and pi-only instances share the
// input stream; expectations come from a standard Keccak rho+pi forward model.
module tb_rho_pi_inv_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;

    logic        b_s_ready;
    logic        b_m_valid;
    logic [63:0] b_m_data;
    logic        b_m_last;
    logic        b_busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] blk_in  [25];
    logic [63:0] exp_out [25];
    logic [63:0] exp_byp [25];
    logic [63:0] state_a [25];

    // Rho offsets indexed x+5y.
    localparam int ROT [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    always #5 clk = ~clk;

    rho_pi_inv_serial #(.BYPASS_RHO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    rho_pi_inv_serial #(.BYPASS_RHO(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last),
        .busy(b_busy)
    );

    function automatic logic [63:0] rotl(input logic [63:0] x, input int k);
        return (k == 0) ? x : ((x << k) | (x >> (64 - k)));
    endfunction

    // pi maps lane (x,y) to position (y, 2x+3y mod 5).
    function automatic int pi_dest(input int m);
        int x, y;
        x = m % 5;
        y = m / 5;
        return y + 5 * ((2 * x + 3 * y) % 5);
    endfunction

    task automatic build_from_state;
        for (int m = 0; m < 25; m++) begin
            blk_in[pi_dest(m)] = rotl(state_a[m], ROT[m]);
            exp_out[m] = state_a[m];
        end
        for (int m = 0; m < 25; m++) exp_byp[m] = blk_in[pi_dest(m)];
    endtask

    task automatic random_state;
        for (int m = 0; m < 25; m++) state_a[m] = {$urandom, $urandom};
        build_from_state();
    endtask

    task automatic clear_vectors;
        for (int m = 0; m < 25; m++) begin
            blk_in[m] = '0;
            exp_out[m] = '0;
            exp_byp[m] = '0;
        end
    endtask

    task automatic send_block(input int unsigned n, input bit gaps, input bit hold);
        int unsigned i = 0;
        int unsigned guard = 0;
        while (i < n && guard < 400) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data = '0;
            end else begin
                s_valid = 1'b1;
                s_data = blk_in[i];
            end
            n_checks++;
            if (busy !== (i != 0)) begin
                n_errors++;
                $display("FAIL fill_busy lane=%0d got=%b want=%b", i, busy, (i != 0));
            end
            n_checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL fill_handshake lane=%0d m_valid=%b s_ready=%b want 0/1", i, m_valid, s_ready);
            end
            if (s_valid && s_ready) i++;
            guard++;
            @(negedge clk);
        end
        n_checks++;
        if (i < n) begin
            n_errors++;
            $display("FAIL fill_timeout accepted=%0d want=%0d", i, n);
        end
        if (n == 25) begin
            n_checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_start m_valid=%b s_ready=%b want 1/0", m_valid, s_ready);
            end
        end
        s_valid = hold;
        s_data = hold ? 64'hDEAD_BEEF_0BAD_F00D : '0;
    endtask

    task automatic recv_block(input int unsigned n, input bit stall);
        int unsigned k = 0;
        int unsigned guard = 0;
        int unsigned hold = 0;
        bit          pstall = 1'b0;
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        while (k < n && guard < 600) begin
            if (stall) begin
                if (hold == 0) begin
                    m_ready = 1'($urandom_range(0, 1));
                    hold = 5;
                end
                hold--;
            end else begin
                m_ready = 1'b1;
            end
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== exp_out[k] || m_last !== (k == 24)) begin
                n_errors++;
                $display("FAIL drain_lane lane=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, m_valid, m_data, m_last, exp_out[k], (k == 24));
            end
            n_checks++;
            if (b_m_valid !== 1'b1 || b_m_data !== exp_byp[k] || b_m_last !== (k == 24)) begin
                n_errors++;
                $display("FAIL bypass_lane lane=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, b_m_valid, b_m_data, b_m_last, exp_byp[k], (k == 24));
            end
            n_checks++;
            if (s_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_flags lane=%0d s_ready=%b busy=%b want 0/1", k, s_ready, busy);
            end
            if (pstall) begin
                n_checks++;
                if (m_data !== pd || m_last !== pl) begin
                    n_errors++;
                    $display("FAIL stall_hold lane=%0d got d=%h l=%b want d=%h l=%b", k, m_data, m_last, pd, pl);
                end
            end
            pstall = !m_ready;
            pd = m_data;
            pl = m_last;
            if (m_ready) k++;
            guard++;
            @(negedge clk);
        end
        n_checks++;
        if (k < n) begin
            n_errors++;
            $display("FAIL drain_timeout emitted=%0d want=%0d", k, n);
        end
        if (n == 25) begin
            n_checks++;
            if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_end s_ready=%b m_valid=%b busy=%b want 1/0/0", s_ready, m_valid, busy);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_data !== 64'h0) begin
            n_errors++;
            $display("FAIL in_reset s_ready=%b m_valid=%b busy=%b m_last=%b m_data=%h want all 0",
                     s_ready, m_valid, busy, m_last, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset s_ready=%b m_valid=%b busy=%b want 1/0/0", s_ready, m_valid, busy);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        do_reset();
        @(negedge clk);
    endtask

    task automatic test_single_bit_lane5;
        clear_vectors();
        blk_in[5]  = 64'h1;
        exp_out[3] = 64'h0000_0010_0000_0000;
        exp_byp[3] = 64'h1;
        send_block(25, 1'b0, 1'b0);
        recv_block(25, 1'b0);
    endtask

    task automatic test_single_bit_lane10;
        clear_vectors();
        blk_in[10] = 64'h1;
        exp_out[1] = 64'h8000_0000_0000_0000;
        exp_byp[1] = 64'h1;
        send_block(25, 1'b0, 1'b0);
        recv_block(25, 1'b0);
    endtask

    task automatic test_round_trip;
        random_state();
        send_block(25, 1'b1, 1'b0);
        recv_block(25, 1'b0);
    endtask

    task automatic test_backpressure;
        random_state();
        send_block(25, 1'b0, 1'b0);
        recv_block(25, 1'b1);
    endtask

    task automatic test_input_during_drain;
        random_state();
        send_block(25, 1'b0, 1'b1);
        recv_block(25, 1'b0);
        random_state();
        send_block(25, 1'b0, 1'b0);
        recv_block(25, 1'b0);
    endtask

    task automatic test_reset_mid_fill;
        random_state();
        send_block(12, 1'b0, 1'b0);
        do_reset();
        random_state();
        send_block(25, 1'b0, 1'b0);
        recv_block(25, 1'b0);
    endtask

    task automatic test_reset_mid_drain;
        random_state();
        send_block(25, 1'b0, 1'b0);
        recv_block(7, 1'b0);
        do_reset();
        random_state();
        send_block(25, 1'b1, 1'b0);
        recv_block(25, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_bit_lane5();
        test_single_bit_lane10();
        test_round_trip();
        test_backpressure();
        test_input_during_drain();
        test_reset_mid_fill();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rho_pi_inv_serial.md
Name: rho_pi_inv_serial

Overview:
- Lane-serial inverse of the Keccak rho+pi step, for the SHA3-256 accelerator.
- Accepts 25 post-rho-pi 64-bit lanes, in index order 0..24, over a valid/ready stream and buffers the full state.
- Emits the pre-rho-pi state lanes in index order 0..24 over a second valid/ready stream.
- Used for round-trip self-check of the permutation datapath and for debug readback through the PS interface.

Parameters:
- BYPASS_RHO, 0, 1 = apply pi^-1 lane reordering only and skip all rotations (debug).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- s_valid  input  1  input lane valid.
- s_ready  output  1  block can accept an input lane.
- s_data  input  64  input lane; lanes arrive strictly in index order 0..24.
- m_valid  output  1  output lane valid.
- m_ready  input  1  downstream accepts the output lane.
- m_data  output  64  output (pre-rho-pi) lane.
- m_last  output  1  high with output lane 24.
- busy  output  1  high from the first input handshake until the lane-24 output handshake.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=FILL, wr_cnt=0, rd_cnt=0.
  - s_ready=0 while rst_n is low; s_ready=1 from the first cycle after release.
  - m_valid=0, m_last=0, m_data=0, busy=0.
  - Buffer contents are don't-care.
- States:
  - FILL: s_ready=1, m_valid=0.
    - On each s_valid&s_ready, buf[wr_cnt]<=s_data and wr_cnt++.
    - On the handshake with wr_cnt==24: wr_cnt<=0, rd_cnt<=0, state<=DRAIN.
  - DRAIN: s_ready=0 (s_valid is ignored), m_valid=1.
    - m_data=rotr(buf[SRC(rd_cnt)], K(rd_cnt)), or rotation 0 when BYPASS_RHO=1.
    - m_last=(rd_cnt==24).
    - On m_valid&m_ready: rd_cnt++; if rd_cnt==24, state<=FILL and rd_cnt<=0.
- Latency and throughput:
  - m_valid rises the cycle after the lane-24 input handshake.
  - s_ready rises the cycle after the lane-24 output handshake.
  - No overlap of fill and drain: minimum 50 cycles per block.
- Backpressure:
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable.
  - Stalls of any length are allowed.
- Input gaps (s_valid=0) in FILL simply pause wr_cnt.
- rotr(x,k) = {x[k-1:0], x[63:k]}, with k=0 meaning identity.
- Inverse table, output lane m: source buffer index SRC, right-rotation K:
  - m0:0,0  m1:10,1  m2:20,62  m3:5,28  m4:15,27
  - m5:16,36  m6:1,44  m7:11,6  m8:21,55  m9:6,20
  - m10:7,3  m11:17,10  m12:2,43  m13:12,25  m14:22,39
  - m15:23,41  m16:8,45  m17:18,15  m18:3,21  m19:13,8
  - m20:14,18  m21:24,2  m22:9,61  m23:19,56  m24:4,14
- SRC is a bijection on 0..24; feeding the forward rho-pi output must reproduce the original state exactly.
- Counters are 5 bits and never exceed 24. There is no wrap past 24: terminal handshakes reload to 0.
- Reset mid-FILL or mid-DRAIN discards the partial block. The next accepted lane is treated as lane 0.
- busy=1 in DRAIN, and in FILL when wr_cnt!=0.

Test Plan:
- Single bit: s lane 5=64'h1, all other lanes 0 -> output lane 3=64'h0000_0010_0000_0000 (bit 36); all other output lanes 0; m_last only on the 25th output.
- Single bit: s lane 10=64'h1 -> output lane 1=64'h8000_0000_0000_0000; with BYPASS_RHO=1 -> output lane 1=64'h1.
- Round trip: random 25-lane state A through the golden forward rho-pi model, fed in -> 25 outputs equal A lane-by-lane; m_valid rises exactly 1 cycle after the lane-24 input handshake.
- Backpressure: m_ready toggles 0/1 randomly with 5-cycle holds -> m_data and m_last stable during every stall; output order and values unchanged; s_ready stays 0 until the lane-24 output handshake, then goes to 1 the next cycle.
- Input during drain: hold s_valid=1 with garbage through DRAIN -> no buffer corruption; the next block's lane 0 is the first lane accepted after s_ready returns to 1.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 12 input lanes (and separately after 7 output lanes) -> m_valid=0, busy=0, s_ready=0 during reset; afterwards a fresh 25-lane block round-trips correctly.
